pipe_stage_reg: RTL and testbench

Parametrised, elastic pipeline stage register for the five-stage CPU datapath, replacing the fixed-field EX/MEM-style registers. It carries a configurable control vector and data payload between stages with a valid/ready handshake. It supports stall, flush (bubble insertion) and an optional skid entry, so upstream ready is fully registered. It also counts squashed instructions for debug.

---
 rtl/pipe_stage_reg.sv | 136 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register: main entry plus optional skid entry with a
// valid/ready handshake, stall, flush and a saturating squash counter.
module pipe_stage_reg #(
    parameter int CTRL_W = 4,
    parameter int DATA_W = 74,
    parameter int SKID   = 1,
    parameter int CNT_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o,
    output logic [1:0]        occ_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              main_v_q, main_v_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic              skid_v_q, skid_v_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [1:0]        occ_q, occ_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic              ready;
    logic              pop;
    logic              push;
    logic [1:0]        n_drop;
    logic [CNT_W+1:0]  cnt_sum;

    // With the skid entry, readiness comes only from the skid-valid register.
    always_comb begin
        if (SKID != 0) begin
            ready = start_i & ~skid_v_q;
        end else begin
            ready = start_i & (~main_v_q | (ready_i & ~stall_i));
        end
    end

    assign ready_o = ready & ~rst_i;
    assign pop     = main_v_q & ready_i & ~stall_i & start_i;
    assign push    = valid_i & ready & start_i & ~flush_i;

    assign n_drop  = {1'b0, main_v_q} + {1'b0, skid_v_q} + {1'b0, valid_i & ready};
    assign cnt_sum = {2'b00, flush_cnt_q} + {{CNT_W{1'b0}}, n_drop};

    always_comb begin
        main_v_d    = main_v_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_v_d    = skid_v_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        flush_cnt_d = flush_cnt_q;
        if (start_i) begin
            if (flush_i) begin
                main_v_d    = 1'b0;
                skid_v_d    = 1'b0;
                main_ctrl_d = '0;
                skid_ctrl_d = '0;
                if (cnt_sum > {2'b00, CNT_MAX}) begin
                    flush_cnt_d = CNT_MAX;
                end else begin
                    flush_cnt_d = cnt_sum[CNT_W-1:0];
                end
            end else if (pop && skid_v_q) begin
                // ready was low, so no push can coincide with this refill
                main_v_d    = 1'b1;
                main_ctrl_d = skid_ctrl_q;
                main_data_d = skid_data_q;
                skid_v_d    = 1'b0;
                skid_ctrl_d = '0;
            end else if (pop) begin
                if (push) begin
                    main_ctrl_d = ctrl_i;
                    main_data_d = data_i;
                end else begin
                    main_v_d    = 1'b0;
                    main_ctrl_d = '0;
                end
            end else if (push) begin
                if (!main_v_q) begin
                    main_v_d    = 1'b1;
                    main_ctrl_d = ctrl_i;
                    main_data_d = data_i;
                end else begin
                    skid_v_d    = 1'b1;
                    skid_ctrl_d = ctrl_i;
                    skid_data_d = data_i;
                end
            end
        end
        occ_d = {1'b0, main_v_d} + {1'b0, skid_v_d};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            main_v_q    <= 1'b0;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_v_q    <= 1'b0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            occ_q       <= '0;
            flush_cnt_q <= '0;
        end else begin
            main_v_q    <= main_v_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_v_q    <= skid_v_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            occ_q       <= occ_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign valid_o     = main_v_q;
    assign ctrl_o      = main_v_q ? main_ctrl_q : '0;
    assign data_o      = main_data_q;
    assign occ_o       = occ_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: skid, no-skid and 2-bit-counter variants
// checked every cycle against a FIFO scoreboard.
module tb_pipe_stage_reg;

    typedef struct packed {
        logic [3:0]  c;
        logic [73:0] d;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b1;
    logic        valid_i = 1'b0, ready_i = 1'b0, stall_i = 1'b0, flush_i = 1'b0;
    logic [3:0]  ctrl_i = '0;
    logic [73:0] data_i = '0;
    logic        b_valid_i = 1'b0, b_ready_i = 1'b0;
    logic [3:0]  b_ctrl_i = '0;
    logic [73:0] b_data_i = '0;
    logic        zero = 1'b0;

    logic        ready_a, valid_a, ready_b, valid_b, ready_c, valid_c;
    logic [3:0]  ctrl_a, ctrl_b, ctrl_c;
    logic [73:0] data_a, data_b, data_c;
    logic [1:0]  occ_a, occ_b, occ_c;
    logic [7:0]  cnt_a, cnt_b;
    logic [1:0]  cnt_c;

    ent_t ma[$];
    ent_t mb[$];
    int   exp_cnt_a = 0;
    int   exp_cnt_c = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    pipe_stage_reg u_a (
        .clk_i(clk), .rst_i(rst), .start_i(start), .valid_i(valid_i), .ready_o(ready_a),
        .ctrl_i(ctrl_i), .data_i(data_i), .stall_i(stall_i), .flush_i(flush_i),
        .valid_o(valid_a), .ready_i(ready_i), .ctrl_o(ctrl_a), .data_o(data_a),
        .occ_o(occ_a), .flush_cnt_o(cnt_a)
    );

    pipe_stage_reg #(.SKID(0)) u_b (
        .clk_i(clk), .rst_i(rst), .start_i(start), .valid_i(b_valid_i), .ready_o(ready_b),
        .ctrl_i(b_ctrl_i), .data_i(b_data_i), .stall_i(zero), .flush_i(zero),
        .valid_o(valid_b), .ready_i(b_ready_i), .ctrl_o(ctrl_b), .data_o(data_b),
        .occ_o(occ_b), .flush_cnt_o(cnt_b)
    );

    pipe_stage_reg #(.CNT_W(2)) u_c (
        .clk_i(clk), .rst_i(rst), .start_i(start), .valid_i(valid_i), .ready_o(ready_c),
        .ctrl_i(ctrl_i), .data_i(data_i), .stall_i(stall_i), .flush_i(flush_i),
        .valid_o(valid_c), .ready_i(ready_i), .ctrl_o(ctrl_c), .data_o(data_c),
        .occ_o(occ_c), .flush_cnt_o(cnt_c)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check all outputs against the scoreboard, then advance the model across one edge.
    task automatic cycle();
        logic ra, rb, pop, push;
        int   addf;
        ent_t e;
        #1;
        ra = start & (ma.size() < 2);
        rb = start & ((mb.size() == 0) | b_ready_i);
        chk("a_ready", ready_a, ra);
        chk("a_valid", valid_a, ma.size() > 0);
        chk("a_occ", occ_a, ma.size());
        chk("a_cnt", cnt_a, exp_cnt_a);
        chk("c_ready", ready_c, ra);
        chk("c_occ", occ_c, ma.size());
        chk("c_cnt", cnt_c, exp_cnt_c);
        chk("b_ready", ready_b, rb);
        chk("b_valid", valid_b, mb.size() > 0);
        chk("b_occ", occ_b, mb.size());
        if (ma.size() > 0) begin
            chk("a_ctrl", ctrl_a, ma[0].c);
            chk("a_data", data_a, ma[0].d);
            chk("c_data", data_c, ma[0].d);
        end else begin
            chk("a_ctrl_bubble", ctrl_a, 0);
        end
        if (mb.size() > 0) begin
            chk("b_ctrl", ctrl_b, mb[0].c);
            chk("b_data", data_b, mb[0].d);
        end else begin
            chk("b_ctrl_bubble", ctrl_b, 0);
        end
        if (start) begin
            if (flush_i) begin
                addf = ma.size() + int'(valid_i & ra);
                exp_cnt_a = (exp_cnt_a + addf > 255) ? 255 : exp_cnt_a + addf;
                exp_cnt_c = (exp_cnt_c + addf > 3) ? 3 : exp_cnt_c + addf;
                ma.delete();
            end else begin
                pop  = (ma.size() > 0) & ready_i & ~stall_i;
                push = valid_i & ra;
                if (pop) void'(ma.pop_front());
                if (push) begin
                    e.c = ctrl_i;
                    e.d = data_i;
                    ma.push_back(e);
                end
            end
            pop  = (mb.size() > 0) & b_ready_i;
            push = b_valid_i & rb;
            if (pop) void'(mb.pop_front());
            if (push) begin
                e.c = b_ctrl_i;
                e.d = b_data_i;
                mb.push_back(e);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input int val);
        valid_i = v;
        data_i  = 74'(val);
        ctrl_i  = 4'(val);
    endtask

    initial begin
        #1;
        chk("rst_valid", valid_a, 1'b0);
        chk("rst_ready", ready_a, 1'b0);
        chk("rst_occ", occ_a, 2'd0);
        chk("rst_cnt", cnt_a, 8'd0);
        chk("rst_data", data_a, 74'd0);
        @(negedge clk);
        rst = 1'b0;

        // streaming
        ready_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, i);
            cycle();
        end
        drive(1'b0, 0);
        cycle();
        cycle();

        // backpressure: A main, B skid, C refused until drained
        stall_i = 1'b1;
        drive(1'b1, 'hA1); cycle();
        drive(1'b1, 'hB2); cycle();
        chk("bp_occ_full", occ_a, 2'd2);
        drive(1'b1, 'hC3); cycle();
        chk("bp_ready_low", ready_a, 1'b0);
        stall_i = 1'b0;
        cycle();
        chk("bp_skid_to_main", data_a, 74'hB2);
        cycle();
        drive(1'b0, 0);
        cycle();
        cycle();
        chk("bp_empty", occ_a, 2'd0);

        // flush with two held, incoming refused
        stall_i = 1'b1;
        drive(1'b1, 'hD4); cycle();
        drive(1'b1, 'hE5); cycle();
        drive(1'b1, 'hF6); flush_i = 1'b1; cycle();
        flush_i = 1'b0; stall_i = 1'b0; drive(1'b0, 0);
        chk("fl1_valid", valid_a, 1'b0);
        chk("fl1_ctrl", ctrl_a, 4'd0);
        chk("fl1_cnt", cnt_a, 8'd2);
        chk("sat1_cnt", cnt_c, 2'd2);
        cycle();

        // flush with one held and an accepted input
        ready_i = 1'b0;
        drive(1'b1, 'h17); cycle();
        drive(1'b1, 'h28); flush_i = 1'b1; cycle();
        flush_i = 1'b0; drive(1'b0, 0);
        chk("fl2_cnt", cnt_a, 8'd4);
        chk("sat2_cnt", cnt_c, 2'd3);
        cycle();

        // third flush, two held: 2-bit counter stays saturated
        stall_i = 1'b1; ready_i = 1'b1;
        drive(1'b1, 'h39); cycle();
        drive(1'b1, 'h4A); cycle();
        drive(1'b0, 0); flush_i = 1'b1; cycle();
        flush_i = 1'b0;
        chk("fl3_cnt", cnt_a, 8'd6);
        chk("sat3_cnt", cnt_c, 2'd3);

        // start low: frozen, flush and valid ignored
        drive(1'b1, 'h5B); cycle();
        start = 1'b0; drive(1'b1, 'h6C); flush_i = 1'b1; stall_i = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        chk("frz_data", data_a, 74'h5B);
        start = 1'b1; flush_i = 1'b0; drive(1'b0, 0);
        cycle();
        cycle();

        // SKID=0 with downstream ready toggling every cycle
        for (int i = 0; i < 16; i++) begin
            b_valid_i = 1'b1;
            b_data_i  = 74'(100 + i);
            b_ctrl_i  = 4'(i + 1);
            b_ready_i = i[0];
            cycle();
        end
        b_valid_i = 1'b0; b_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        chk("b_drained", occ_b, 2'd0);

        // async reset with two held
        stall_i = 1'b1;
        drive(1'b1, 'h7D); cycle();
        drive(1'b1, 'h8E); cycle();
        drive(1'b0, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", valid_a, 1'b0);
        chk("arst_ctrl", ctrl_a, 4'd0);
        chk("arst_data", data_a, 74'd0);
        chk("arst_occ", occ_a, 2'd0);
        chk("arst_cnt", cnt_a, 8'd0);
        chk("arst_ready", ready_a, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        stall_i = 1'b0;
        ma.delete();
        mb.delete();
        exp_cnt_a = 0;
        exp_cnt_c = 0;
        drive(1'b1, 'h9F);
        cycle();
        drive(1'b0, 0);
        cycle();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
